// File: rtl/vec2bram_writer.sv
// vec2bram_writer
// ---------------
// Writes a flat result vector from the PL datapath into port B of the shared
// 2048 x 32-bit block memory. Element i lands at word address BASE_ADDR + i.
// The PS reads the result through port A.
//
// Optional feature (compile-time macro VEC2BRAM_SEQNUM_EN):
//   After every complete vector, a 32-bit sequence word is written at
//   BASE_ADDR + VLEN. The first transfer after reset writes 1, and the count
//   wraps from 0xFFFFFFFF to 0. Software polls this word to know when a
//   complete, consistent vector has landed. Without the macro, that address
//   is never touched.
//
// Parameters:
//   VLEN       number of 32-bit elements (>= 1)
//   BASE_ADDR  word address of element 0 (BASE_ADDR + VLEN + 1 <= 2048)
//
// Ports:
//   clk, rst   clock; synchronous active-high reset
//   vec_in     flat vector, element i = vec_in[32*i +: 32]
//   vec_valid  vec_in holds a new vector
//   vec_ready  block can accept a vector (IDLE and not in reset)
//   busy       transfer in progress (state != IDLE)
//   done       one-cycle pulse after the last BRAM write of a transfer
//   bram_*     port B address / write data / enable / write enable (registered)
//
// Handshake: a vector is transferred on every rising edge where vec_valid and
// vec_ready are both high. vec_valid and vec_in are ignored at all other times,
// and the producer may change or drop them freely while the block is busy.

module vec2bram_writer #(
    parameter int VLEN      = 1,
    parameter int BASE_ADDR = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [32*VLEN-1:0]     vec_in,
    input  logic                   vec_valid,
    output logic                   vec_ready,
    output logic                   busy,
    output logic                   done,
    output logic [10:0]            bram_addr,
    output logic [31:0]            bram_din,
    output logic                   bram_en,
    output logic                   bram_we
);

    localparam int IW = $clog2(VLEN + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(VLEN - 1);

`ifdef VEC2BRAM_SEQNUM_EN
    typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, DONE = 2'd2, SEQ = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, DONE = 2'd2} state_t;
`endif

    state_t state;
    state_t next_state;

    // The shadow holds the words that have not been driven yet, with the next
    // one in bits [31:0]. Word 0 goes straight from vec_in to bram_din at the
    // accepting edge, so the shadow is loaded with the remaining words only.
    logic [32*VLEN-1:0] shadow;
    logic [IW-1:0]      idx;     // index of the word currently on the port
    logic               accept;
    logic               last_word;

`ifdef VEC2BRAM_SEQNUM_EN
    logic [31:0] seq_cnt;
`endif

    assign vec_ready = (state == IDLE) && !rst;
    assign busy      = (state != IDLE);
    assign accept    = vec_valid && vec_ready;
    assign last_word = (idx == LAST_IDX);

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = WRITE;
                end
            end
            WRITE: begin
                if (last_word) begin
`ifdef VEC2BRAM_SEQNUM_EN
                    next_state = SEQ;
`else
                    next_state = DONE;
`endif
                end
            end
`ifdef VEC2BRAM_SEQNUM_EN
            SEQ:     next_state = DONE;
`endif
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // ---------------- datapath and registered port outputs ----------------
    // The outputs for cycle n+1 are computed from the state in cycle n. As a
    // result, the word registered at the accepting edge is on the port during
    // the very next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            bram_en   <= 1'b0;
            bram_we   <= 1'b0;
            bram_addr <= 11'd0;
            bram_din  <= 32'd0;
            done      <= 1'b0;
            idx       <= '0;
`ifdef VEC2BRAM_SEQNUM_EN
            seq_cnt   <= 32'd0;
`endif
        end else begin
            bram_en <= 1'b0;
            bram_we <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        shadow    <= vec_in >> 32;
                        idx       <= '0;
                        bram_en   <= 1'b1;
                        bram_we   <= 1'b1;
                        bram_addr <= 11'(BASE_ADDR);
                        bram_din  <= vec_in[31:0];
                    end
                end
                WRITE: begin
                    if (!last_word) begin
                        idx       <= idx + 1'b1;
                        shadow    <= shadow >> 32;
                        bram_en   <= 1'b1;
                        bram_we   <= 1'b1;
                        bram_addr <= 11'(BASE_ADDR + 32'(idx) + 1);
                        bram_din  <= shadow[31:0];
                    end else begin
`ifdef VEC2BRAM_SEQNUM_EN
                        bram_en   <= 1'b1;
                        bram_we   <= 1'b1;
                        bram_addr <= 11'(BASE_ADDR + VLEN);
                        bram_din  <= seq_cnt + 32'd1;
                        seq_cnt   <= seq_cnt + 32'd1;
`else
                        done      <= 1'b1;
`endif
                    end
                end
`ifdef VEC2BRAM_SEQNUM_EN
                SEQ: begin
                    done <= 1'b1;
                end
`endif
                default: begin
                end
            endcase
        end
    end

endmodule
